// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: shared types and format constants for the LZRW1 stream decompressor.
//   decomp_state_t : FSM states (IDLE accepts items, COPY streams a back-reference)
//   copy_item_t    : field layout of a copy item {len-3, offset}
package lzrw1_pkg;

    localparam int LZRW1_MIN_MATCH    = 3;
    localparam int LZRW1_OFFSET_WIDTH = 12;
    localparam int LZRW1_LEN_WIDTH    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } decomp_state_t;

    typedef struct packed {
        logic [LZRW1_LEN_WIDTH-1:0]    len;     // copy length minus LZRW1_MIN_MATCH
        logic [LZRW1_OFFSET_WIDTH-1:0] offset;  // distance back into history
    } copy_item_t;

endpackage

// File: rtl/lzrw1_history_buf.sv
// lzrw1_history_buf: circular byte history for the LZRW1 decompressor.
//   clock    in   rising-edge clock
//   rd_base  in   address of read lane 0; lane i reads rd_base+i (wraps)
//   rd_data  out  OUT_BYTES combinational read lanes, lane i = [8i+7:8i]
//   wr_base  in   address of write lane 0; lane i writes wr_base+i (wraps)
//   wr_mask  in   per-lane write enable
//   wr_data  in   OUT_BYTES write lanes
module lzrw1_history_buf #(
    parameter int HISTORY_SIZE = 256,
    parameter int OUT_BYTES    = 4,
    localparam int PTR_W       = $clog2(HISTORY_SIZE)
) (
    input  logic                   clock,
    input  logic [PTR_W-1:0]       rd_base,
    output logic [8*OUT_BYTES-1:0] rd_data,
    input  logic [PTR_W-1:0]       wr_base,
    input  logic [OUT_BYTES-1:0]   wr_mask,
    input  logic [8*OUT_BYTES-1:0] wr_data
);

    logic [7:0] mem [HISTORY_SIZE];

    // NOTE: the history array has no reset; its contents are only ever read
    // after being written, so clearing it would just add a wide reset fan-out.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (wr_mask[i]) begin
                mem[wr_base + PTR_W'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            rd_data[8*i +: 8] = mem[rd_base + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/lzrw1_stream_decompressor.sv
// lzrw1_stream_decompressor: LZRW1 item decoder emitting up to OUT_BYTES bytes per beat.
//   clock            in   rising-edge clock
//   reset_n          in   synchronous active-low reset
//   data_in          in   item: literal in [7:0]; copy = {len-3[15:12], offset[11:0]}
//   control_word_in  in   0 = literal, 1 = copy
//   in_valid/in_ready     item handshake (in_ready combinational)
//   out_data         out  lane i = [8i+7:8i], lane 0 oldest
//   out_count        out  valid lanes in beat
//   out_valid/out_ready   beat handshake; beat held stable while stalled
//   bytes_out        out  running count of handed-over bytes (wraps)
//   error            out  sticky bad-copy flag
// Build option: define LZRW1_DECOMP_ERR_EN to enable copy-offset checking;
// otherwise error is tied low.
module lzrw1_stream_decompressor
    import lzrw1_pkg::*;
#(
    parameter int HISTORY_SIZE = 256,
    parameter int OUT_BYTES    = 4,
    parameter int OFFSET_WIDTH = 12,
    parameter int LEN_WIDTH    = 4,
    localparam int PTR_W       = $clog2(HISTORY_SIZE),
    localparam int CNT_W       = $clog2(OUT_BYTES) + 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [15:0]            data_in,
    input  logic                   control_word_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            bytes_out,
    output logic                   error
);

    localparam int REM_W = LEN_WIDTH + 1;

    decomp_state_t          state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       copy_off;   // effective offset, never 0
    logic [REM_W-1:0]       rem;

    copy_item_t             cmd;
    logic [OFFSET_WIDTH-1:0] cmd_offset;
    logic [PTR_W-1:0]       cmd_eff_off;
    logic [REM_W-1:0]       cmd_rem;

    logic                   out_free;
    logic                   in_fire;
    logic                   copy_go;

    logic [15:0]            n_wide;
    logic [CNT_W-1:0]       copy_n;
    logic [OUT_BYTES-1:0]   copy_mask;
    logic [8*OUT_BYTES-1:0] copy_data;

    logic [PTR_W-1:0]       rd_base;
    logic [8*OUT_BYTES-1:0] rd_data;
    logic [OUT_BYTES-1:0]   wr_mask;
    logic [8*OUT_BYTES-1:0] wr_data;

    assign cmd         = copy_item_t'(data_in);
    assign cmd_offset  = cmd.offset;
    // Offset is used modulo the history depth; a zero offset degrades to 1.
    assign cmd_eff_off = (cmd_offset[PTR_W-1:0] == '0) ? PTR_W'(1) : cmd_offset[PTR_W-1:0];
    assign cmd_rem     = REM_W'(cmd.len) + REM_W'(LZRW1_MIN_MATCH);

    assign out_free = !out_valid || out_ready;
    assign in_ready = reset_n && (state == IDLE) && out_free;
    assign in_fire  = in_valid && in_ready;
    assign copy_go  = reset_n && (state == COPY) && out_free;
    assign rd_base  = wr_ptr - copy_off;

    // Beat size is capped by the offset so no lane reads a byte that is being
    // written on the same edge (overlapping copies such as offset 1 runs).
    // NOTE: every variable assigned here gets a default first, otherwise a
    // path that skips an assignment would infer a latch.
    always_comb begin
        n_wide = 16'(OUT_BYTES);
        if (16'(rem) < n_wide)      n_wide = 16'(rem);
        if (16'(copy_off) < n_wide) n_wide = 16'(copy_off);
        copy_n    = CNT_W'(n_wide);
        copy_mask = '0;
        copy_data = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (i < int'(n_wide)) begin
                copy_mask[i]        = 1'b1;
                copy_data[8*i +: 8] = rd_data[8*i +: 8];
            end
        end
    end

    // A copy re-writes the bytes it emits at the head of the history.
    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        if (in_fire && !control_word_in) begin
            wr_mask[0]   = 1'b1;
            wr_data[7:0] = data_in[7:0];
        end else if (copy_go) begin
            wr_mask = copy_mask;
            wr_data = copy_data;
        end
    end

    lzrw1_history_buf #(
        .HISTORY_SIZE (HISTORY_SIZE),
        .OUT_BYTES    (OUT_BYTES)
    ) u_hist (
        .clock   (clock),
        .rd_base (rd_base),
        .rd_data (rd_data),
        .wr_base (wr_ptr),
        .wr_mask (wr_mask),
        .wr_data (wr_data)
    );

`ifdef LZRW1_DECOMP_ERR_EN
    logic [PTR_W:0] hist_fill;
    logic           cmd_bad;

    assign cmd_bad = (cmd_offset == '0)
                  || (32'(cmd_offset) >= HISTORY_SIZE)
                  || (32'(cmd_offset) > 32'(hist_fill));

    function automatic logic [PTR_W:0] fill_add(input logic [PTR_W:0] fill,
                                                input logic [CNT_W-1:0] n);
        if (32'(fill) + 32'(n) >= HISTORY_SIZE) return (PTR_W+1)'(HISTORY_SIZE);
        return fill + (PTR_W+1)'(n);
    endfunction
`else
    logic unused_offset;
    assign unused_offset = ^cmd_offset;
    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            bytes_out <= '0;
            wr_ptr    <= '0;
            copy_off  <= PTR_W'(1);
            rem       <= '0;
`ifdef LZRW1_DECOMP_ERR_EN
            hist_fill <= '0;
            error     <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                bytes_out <= bytes_out + 32'(out_count);
            end
            // Drained beat retires unless a new beat is loaded below.
            if (out_free) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (control_word_in) begin
                            copy_off <= cmd_eff_off;
                            rem      <= cmd_rem;
                            state    <= COPY;
`ifdef LZRW1_DECOMP_ERR_EN
                            if (cmd_bad) error <= 1'b1;
`endif
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= (8*OUT_BYTES)'(data_in[7:0]);
                            out_count <= CNT_W'(1);
                            wr_ptr    <= wr_ptr + PTR_W'(1);
`ifdef LZRW1_DECOMP_ERR_EN
                            hist_fill <= fill_add(hist_fill, CNT_W'(1));
`endif
                        end
                    end
                end
                COPY: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= copy_data;
                        out_count <= copy_n;
                        wr_ptr    <= wr_ptr + PTR_W'(copy_n);
                        rem       <= rem - REM_W'(copy_n);
                        if (rem == REM_W'(copy_n)) state <= IDLE;
`ifdef LZRW1_DECOMP_ERR_EN
                        hist_fill <= fill_add(hist_fill, copy_n);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
